pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles a MEM-stage access may wait before error.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 id_rs1_addr, id_rs2_addr  input  5 each  source registers of the ID-stage instruction.
REQ-005 id_rs1_use, id_rs2_use  input  1 each  ID instruction actually reads rs1/rs2.
REQ-006 exe_rd_addr  input  5  destination register of the EXE-stage instruction.
REQ-007 exe_memread  input  1  EXE instruction is a load.
REQ-008 exe_redirect  input  1  branch taken or jump resolved in EXE.
REQ-009 mem_req  input  1  MEM-stage instruction accesses data memory (MemRead or MemWrite).
REQ-010 dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_en, ifid_en, idexe_en, exemem_en, memwb_en  output  1 each  load enables for the PC and pipeline registers.
REQ-012 ifid_flush, idexe_flush, exemem_flush, memwb_flush  output  1 each  load a bubble (all control bits 0) into that register.
REQ-013 dmem_err  output  1  sticky memory-timeout error.
REQ-014 stall_cycles  output  32  stall-cycle count; present only under PERF_CNT_EN.

Function
REQ-015 Controller SHALL hold states IDLE, WAIT, ERR; all enable/flush outputs combinational from state and inputs.
REQ-016 Memory stall: in IDLE or WAIT with mem_req=1 and dmem_ready=0, pc/ifid/idexe/exemem_en=0, memwb_en=1, memwb_flush=1, all other flushes 0.
REQ-017 IDLE -> WAIT when mem_req=1 and dmem_ready=0; WAIT -> IDLE when dmem_ready=1, that cycle treated as non-stalled.
REQ-018 Wait counter SHALL clear on entry to WAIT, increment each WAIT cycle; reaching TIMEOUT with dmem_ready=0 -> ERR.
REQ-019 ERR: all enables 0, all flushes 1, dmem_err=1; exit only by reset.
REQ-020 Redirect (no memory stall): exe_redirect=1 -> pc_en=1, ifid_flush=1, idexe_flush=1, others enabled, no flush of exemem.
REQ-021 Load-use (no memory stall, no redirect): exe_memread=1, exe_rd_addr!=0, and (id_rs1_use and rs1 match, or id_rs2_use and rs2 match) -> pc_en=0, ifid_en=0, idexe_flush=1, exemem/memwb enabled.
REQ-022 Priority SHALL be ERR > memory stall > redirect > load-use > normal (all enables 1, all flushes 0).
REQ-023 exe_redirect held during a memory stall SHALL be acted upon in the release cycle (dmem_ready=1).
REQ-024 dmem_ready=1 with mem_req=0 SHALL be ignored.

Reset
REQ-025 While reset=1: state IDLE, wait counter 0, dmem_err 0, all enables 0, all flushes 1, stall_cycles 0.
REQ-026 Reset asserted mid-WAIT SHALL abort the wait immediately; first cycle after release behaves as IDLE.

Configuration
REQ-027 With PERF_CNT_EN defined: stall_cycles increments (wrapping at 2^32) every cycle pc_en=0 outside reset and ERR; without it the port and counter are absent.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state enum, TIMEOUT default, and bubble-control constants.
REQ-029 Memory FSM and wait counter SHALL be sub-module dmem_wait_fsm; hazard priority logic stays in the top.

Verification
REQ-030 exe_memread=1, exe_rd=5, id_rs1=5, id_rs1_use=1 -> pc_en=0, ifid_en=0, idexe_flush=1 for one cycle.
REQ-031 Same with exe_rd=0 -> no stall, all enables 1.
REQ-032 mem_req=1, dmem_ready low 3 cycles then high -> 3 cycles upstream frozen with memwb_flush=1, fourth cycle all enabled, state IDLE.
REQ-033 exe_redirect=1 during memory stall, released by dmem_ready -> flushes only in release cycle; stall_cycles +3 with PERF_CNT_EN.
REQ-034 TIMEOUT=4, dmem_ready held 0 -> ERR after 4 WAIT cycles, dmem_err=1 until reset, cleared on reset.
REQ-035 Reset pulse in WAIT -> outputs at reset values, IDLE after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control bundles order enables then flushes, upstream to downstream.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idexe_en;
        logic exemem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idexe_flush;
        logic exemem_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL   = 9'b11111_0000;
    localparam ctrl_t CTRL_HALT     = 9'b00000_1111;
    localparam ctrl_t CTRL_MEMSTALL = 9'b00001_0001;
    localparam ctrl_t CTRL_REDIRECT = 9'b11111_1100;
    localparam ctrl_t CTRL_LOADUSE  = 9'b00111_0100;

endpackage

// File: rtl/dmem_wait_fsm.sv
// Data-memory wait tracker: IDLE/WAIT/ERR with a bounded wait counter.
// ERR is sticky until reset.
module dmem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_req,
    input  logic dmem_ready,
    output logic stall,
    output logic err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    assign stall = (state != ERR) && mem_req && !dmem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_req && !dmem_ready) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    // A withdrawn request ends the wait just like completion.
                    if (!mem_req || dmem_ready) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    state <= ERR;
                    err   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory stall, redirect and load-use arbitration.
// Optional stall-cycle counter enabled by PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_use,
    input  logic       id_rs2_use,
    input  logic [4:0] exe_rd_addr,
    input  logic       exe_memread,
    input  logic       exe_redirect,
    input  logic       mem_req,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idexe_en,
    output logic       exemem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idexe_flush,
    output logic       exemem_flush,
    output logic       memwb_flush,
    output logic       dmem_err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic  mem_stall;
    logic  load_use;
    ctrl_t ctrl;

    dmem_wait_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .dmem_ready(dmem_ready),
        .stall     (mem_stall),
        .err       (dmem_err)
    );

    assign load_use = exe_memread && (exe_rd_addr != 5'd0) &&
                      ((id_rs1_use && (id_rs1_addr == exe_rd_addr)) ||
                       (id_rs2_use && (id_rs2_addr == exe_rd_addr)));

    always_comb begin
        ctrl = CTRL_NORMAL;
        if (reset || dmem_err) begin
            ctrl = CTRL_HALT;
        end else if (mem_stall) begin
            ctrl = CTRL_MEMSTALL;
        end else if (exe_redirect) begin
            ctrl = CTRL_REDIRECT;
        end else if (load_use) begin
            ctrl = CTRL_LOADUSE;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign idexe_en     = ctrl.idexe_en;
    assign exemem_en    = ctrl.exemem_en;
    assign memwb_en     = ctrl.memwb_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idexe_flush  = ctrl.idexe_flush;
    assign exemem_flush = ctrl.exemem_flush;
    assign memwb_flush  = ctrl.memwb_flush;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && !dmem_err) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed steps then random traffic
// against a priority-rule model with a stall-run timeout count.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1_addr, id_rs2_addr, exe_rd_addr;
    logic       id_rs1_use, id_rs2_use;
    logic       exe_memread, exe_redirect, mem_req, dmem_ready;
    logic       pc_en, ifid_en, idexe_en, exemem_en, memwb_en;
    logic       ifid_flush, idexe_flush, exemem_flush, memwb_flush;
    logic       dmem_err;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic        m_err = 1'b0;
    int          m_run = 0;
    logic [31:0] m_cnt = 32'd0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_use  (id_rs1_use),
        .id_rs2_use  (id_rs2_use),
        .exe_rd_addr (exe_rd_addr),
        .exe_memread (exe_memread),
        .exe_redirect(exe_redirect),
        .mem_req     (mem_req),
        .dmem_ready  (dmem_ready),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idexe_en    (idexe_en),
        .exemem_en   (exemem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idexe_flush (idexe_flush),
        .exemem_flush(exemem_flush),
        .memwb_flush (memwb_flush),
        .dmem_err    (dmem_err)
`ifdef PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [8:0] expect_ctrl();
        logic lu;
        lu = exe_memread && (exe_rd_addr != 5'd0) &&
             ((id_rs1_use && id_rs1_addr == exe_rd_addr) ||
              (id_rs2_use && id_rs2_addr == exe_rd_addr));
        if (reset || m_err)              return 9'b00000_1111;
        if (mem_req && !dmem_ready)      return 9'b00001_0001;
        if (exe_redirect)                return 9'b11111_1100;
        if (lu)                          return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    function automatic logic [8:0] observed();
        return {pc_en, ifid_en, idexe_en, exemem_en, memwb_en,
                ifid_flush, idexe_flush, exemem_flush, memwb_flush};
    endfunction

    task automatic check(input string tag);
        logic [8:0] e;
        logic [8:0] o;
        e = expect_ctrl();
        o = observed();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, o, e);
        end
        tests++;
        assert (dmem_err === (m_err && !reset)) else begin
            fails++;
            $error("FAIL %s dmem_err observed=%b expected=%b",
                   tag, dmem_err, m_err && !reset);
        end
`ifdef PERF_CNT_EN
        tests++;
        assert (stall_cycles === m_cnt) else begin
            fails++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d",
                   tag, stall_cycles, m_cnt);
        end
`endif
    endtask

    // Check mid-cycle, then advance the model across the rising edge.
    task automatic cycle(input string tag);
        logic [8:0] e;
        @(negedge clk);
        check(tag);
        e = expect_ctrl();
        @(posedge clk);
        if (reset) begin
            m_err = 1'b0;
            m_run = 0;
            m_cnt = 32'd0;
        end else if (!m_err) begin
            if (!e[8]) m_cnt = m_cnt + 32'd1;
            if (mem_req && !dmem_ready) begin
                m_run++;
                if (m_run == TO + 1) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1_addr  = 5'd0;
        id_rs2_addr  = 5'd0;
        id_rs1_use   = 1'b0;
        id_rs2_use   = 1'b0;
        exe_rd_addr  = 5'd0;
        exe_memread  = 1'b0;
        exe_redirect = 1'b0;
        mem_req      = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    initial begin
        logic [31:0] c0;
        idle_inputs();
        reset = 1'b1;
        cycle("reset");
        cycle("reset2");
        reset = 1'b0;
        cycle("normal");

        exe_memread = 1'b1; exe_rd_addr = 5'd5;
        id_rs1_addr = 5'd5; id_rs1_use = 1'b1;
        cycle("loaduse_rs1");
        exe_rd_addr = 5'd0; id_rs1_addr = 5'd0;
        cycle("loaduse_x0");
        exe_rd_addr = 5'd7; id_rs1_addr = 5'd1;
        id_rs2_addr = 5'd7; id_rs2_use = 1'b0;
        cycle("rs2_unused");
        id_rs2_use = 1'b1;
        cycle("loaduse_rs2");
        exe_redirect = 1'b1;
        cycle("redirect_over_lu");
        idle_inputs();

        // Memory stall with redirect held, released on cycle four
        c0 = m_cnt;
        mem_req = 1'b1; exe_redirect = 1'b1;
        repeat (3) cycle("memstall_redir");
        dmem_ready = 1'b1;
        cycle("release_redir");
        tests++;
        assert (m_cnt - c0 == 32'd3) else begin
            fails++;
            $error("FAIL model_stall_delta observed=%0d expected=3", m_cnt - c0);
        end
        idle_inputs();
        cycle("after_release");

        mem_req = 1'b1;
        repeat (3) cycle("memstall");
        dmem_ready = 1'b1;
        cycle("release");
        dmem_ready = 1'b0;
        cycle("new_stall_from_idle");
        idle_inputs();
        mem_req = 1'b0; dmem_ready = 1'b1;
        cycle("ready_no_req");

        // Timeout into ERR
        dmem_ready = 1'b0; mem_req = 1'b1;
        repeat (TO + 1) cycle("pre_timeout");
        repeat (3) cycle("err_sticky");
        dmem_ready = 1'b1;
        cycle("err_ready");
        reset = 1'b1;
        cycle("err_reset");
        reset = 1'b0;
        idle_inputs();
        cycle("err_cleared");

        // Asynchronous reset mid-wait
        mem_req = 1'b1;
        repeat (2) cycle("wait_before_rst");
        #2 reset = 1'b1;
        #1 check("async_reset");
        m_err = 1'b0; m_run = 0; m_cnt = 32'd0;
        cycle("in_reset");
        reset = 1'b0;
        idle_inputs();
        cycle("idle_after_rst");

        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            id_rs1_addr  = 5'($urandom_range(0, 3));
            id_rs2_addr  = 5'($urandom_range(0, 3));
            exe_rd_addr  = 5'($urandom_range(0, 3));
            id_rs1_use   = 1'($urandom);
            id_rs2_use   = 1'($urandom);
            exe_memread  = 1'($urandom);
            exe_redirect = ($urandom_range(0, 3) == 0);
            mem_req      = 1'($urandom);
            dmem_ready   = ($urandom_range(0, 3) == 0);
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
